bomb_game_controller: RTL and testbench

BOMB_GAME_CONTROLLER -- requirements
Module: bomb_game_controller

---
 rtl/game_pkg.sv | 33 +++
 rtl/bomb_arbiter.sv | 39 +++
 rtl/bomb_game_controller.sv | 192 +++++++++++++++++++
 tb/tb_bomb_game_controller.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared encodings, widths and parameter defaults for the bomb game.
package game_pkg;

    typedef enum logic [1:0] {
        QI      = 2'b00,
        QGAME_1 = 2'b01,
        QGAME_2 = 2'b10,
        QDONE   = 2'b11
    } state_t;

    localparam int COORD_W = 10;
    localparam int DIST_W  = COORD_W + 1;
    localparam int RAD_W   = 6;
    localparam int SCORE_W = 4;

    localparam int DEF_FUSE_TICKS = 32;
    localparam int DEF_RAD_INIT   = 5;
    localparam int DEF_RAD_STEP   = 5;
    localparam int DEF_RAD_MAX    = 40;
    localparam int DEF_WIN_SCORE  = 10;

    function automatic logic [DIST_W-1:0] abs_diff(
        input logic [COORD_W-1:0] a,
        input logic [COORD_W-1:0] b
    );
        logic [DIST_W-1:0] w_a;
        logic [DIST_W-1:0] w_b;
        w_a = {1'b0, a};
        w_b = {1'b0, b};
        return (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
    endfunction

endpackage

// File: rtl/bomb_arbiter.sv
// Two-way round-robin bomb arbiter; the pointer remembers the last winner.
module bomb_arbiter (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_req1,
    input  logic i_req2,
    output logic o_gnt1,
    output logic o_gnt2
);

    // Set when P2 won last, which gives P1 priority on a tie.
    logic r_last_p2;

    always_comb begin
        o_gnt1 = 1'b0;
        o_gnt2 = 1'b0;
        if (i_en) begin
            if (i_req1 && i_req2) begin
                o_gnt1 = r_last_p2;
                o_gnt2 = !r_last_p2;
            end else begin
                o_gnt1 = i_req1;
                o_gnt2 = i_req2;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_p2 <= 1'b1;
        end else if (o_gnt1) begin
            r_last_p2 <= 1'b0;
        end else if (o_gnt2) begin
            r_last_p2 <= 1'b1;
        end
    end

endmodule

// File: rtl/bomb_game_controller.sv
// Two-player bomb game: one shared bomb slot, fuse, growing blast, scoring.
module bomb_game_controller
    import game_pkg::*;
#(
    parameter int FUSE_TICKS = DEF_FUSE_TICKS,
    parameter int RAD_INIT   = DEF_RAD_INIT,
    parameter int RAD_STEP   = DEF_RAD_STEP,
    parameter int RAD_MAX    = DEF_RAD_MAX,
    parameter int WIN_SCORE  = DEF_WIN_SCORE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic               p1_req,
    input  logic               p2_req,
    input  logic [COORD_W-1:0] p1_x,
    input  logic [COORD_W-1:0] p1_y,
    input  logic [COORD_W-1:0] p2_x,
    input  logic [COORD_W-1:0] p2_y,
    output logic               bomb_active,
    output logic [COORD_W-1:0] bomb_x,
    output logic [COORD_W-1:0] bomb_y,
    output logic [RAD_W-1:0]   bomb_rad,
    output logic               bomb_owner,
    output logic               p1_grant,
    output logic               p2_grant,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [1:0]         state
);

    localparam int FUSE_W = $clog2(FUSE_TICKS + 1);
    localparam logic [SCORE_W-1:0] L_WIN = SCORE_W'(WIN_SCORE);
    localparam logic [RAD_W-1:0]   L_MAX = RAD_W'(RAD_MAX);

    state_t             r_state;
    logic               r_active;
    logic [COORD_W-1:0] r_bx;
    logic [COORD_W-1:0] r_by;
    logic [RAD_W-1:0]   r_rad;
    logic               r_owner;
    logic               r_g1;
    logic               r_g2;
    logic [SCORE_W-1:0] r_s1;
    logic [SCORE_W-1:0] r_s2;
    logic [FUSE_W-1:0]  r_fuse;
    logic               r_h1;
    logic               r_h2;

    logic               w_arb_en;
    logic               w_g1;
    logic               w_g2;
    logic [DIST_W-1:0]  w_rad_ext;
    logic               w_hit1;
    logic               w_hit2;
    logic               w_new1;
    logic               w_new2;
    logic [SCORE_W-1:0] w_s1n;
    logic [SCORE_W-1:0] w_s2n;
    logic               w_win;
    logic [RAD_W:0]     w_rad_sum;
    logic [RAD_W-1:0]   w_rad_next;

    assign w_arb_en = tick && start && (r_state == QGAME_1) && !r_active;

    bomb_arbiter u_arb (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_arb_en),
        .i_req1 (p1_req),
        .i_req2 (p2_req),
        .o_gnt1 (w_g1),
        .o_gnt2 (w_g2)
    );

    assign w_rad_ext = {{(DIST_W - RAD_W){1'b0}}, r_rad};
    assign w_hit1 = (abs_diff(p1_x, r_bx) <= w_rad_ext)
                 && (abs_diff(p1_y, r_by) <= w_rad_ext);
    assign w_hit2 = (abs_diff(p2_x, r_bx) <= w_rad_ext)
                 && (abs_diff(p2_y, r_by) <= w_rad_ext);
    assign w_new1 = w_hit1 && !r_h1;
    assign w_new2 = w_hit2 && !r_h2;

    // Owner-hit credits the opponent, other-hit credits the owner:
    // either way the player who was not hit gains the point.
    assign w_s1n = (w_new2 && (r_s1 < L_WIN)) ? r_s1 + 1'b1 : r_s1;
    assign w_s2n = (w_new1 && (r_s2 < L_WIN)) ? r_s2 + 1'b1 : r_s2;
    assign w_win = (w_s1n == L_WIN) || (w_s2n == L_WIN);

    assign w_rad_sum  = {1'b0, r_rad} + (RAD_W + 1)'(RAD_STEP);
    assign w_rad_next = (w_rad_sum >= (RAD_W + 1)'(RAD_MAX))
                      ? L_MAX : w_rad_sum[RAD_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= QI;
            r_active <= 1'b0;
            r_bx     <= '0;
            r_by     <= '0;
            r_rad    <= '0;
            r_owner  <= 1'b0;
            r_g1     <= 1'b0;
            r_g2     <= 1'b0;
            r_s1     <= '0;
            r_s2     <= '0;
            r_fuse   <= '0;
            r_h1     <= 1'b0;
            r_h2     <= 1'b0;
        end else begin
            r_g1 <= 1'b0;
            r_g2 <= 1'b0;
            if (tick) begin
                unique case (r_state)
                    QI: begin
                        if (start) begin
                            r_s1     <= '0;
                            r_s2     <= '0;
                            r_h1     <= 1'b0;
                            r_h2     <= 1'b0;
                            r_active <= 1'b0;
                            r_state  <= QGAME_1;
                        end
                    end
                    QGAME_1: begin
                        if (!start) begin
                            r_state  <= QI;
                            r_active <= 1'b0;
                            r_rad    <= '0;
                            r_fuse   <= '0;
                        end else if (w_g1 || w_g2) begin
                            r_g1     <= w_g1;
                            r_g2     <= w_g2;
                            r_owner  <= w_g2;
                            r_bx     <= w_g2 ? p2_x : p1_x;
                            r_by     <= w_g2 ? p2_y : p1_y;
                            r_active <= 1'b1;
                            r_fuse   <= FUSE_W'(FUSE_TICKS);
                        end else if (r_active) begin
                            r_fuse <= r_fuse - 1'b1;
                            if (r_fuse == FUSE_W'(1)) begin
                                r_state <= QGAME_2;
                                r_rad   <= RAD_W'(RAD_INIT);
                                r_h1    <= 1'b0;
                                r_h2    <= 1'b0;
                            end
                        end
                    end
                    QGAME_2: begin
                        r_h1 <= r_h1 | w_hit1;
                        r_h2 <= r_h2 | w_hit2;
                        r_s1 <= w_s1n;
                        r_s2 <= w_s2n;
                        if (w_win) begin
                            r_state  <= QDONE;
                            r_active <= 1'b0;
                            r_rad    <= '0;
                        end else if (!start) begin
                            r_state  <= QI;
                            r_active <= 1'b0;
                            r_rad    <= '0;
                        end else if (r_rad == L_MAX) begin
                            r_state  <= QGAME_1;
                            r_active <= 1'b0;
                            r_rad    <= '0;
                        end else begin
                            r_rad <= w_rad_next;
                        end
                    end
                    QDONE: begin
                        if (!start) begin
                            r_state <= QI;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign state       = r_state;
    assign bomb_active = r_active;
    assign bomb_x      = r_bx;
    assign bomb_y      = r_by;
    assign bomb_rad    = r_rad;
    assign bomb_owner  = r_owner;
    assign p1_grant    = r_g1;
    assign p2_grant    = r_g2;
    assign p1_score    = r_s1;
    assign p2_score    = r_s2;

endmodule

// File: tb/tb_bomb_game_controller.sv
// Scoreboard bench for bomb_game_controller with a rule-level game model.
module tb_bomb_game_controller;

    localparam int FUSE = 32;
    localparam int RI   = 5;
    localparam int RS   = 5;
    localparam int RM   = 40;
    localparam int WIN  = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       p1_req = 1'b0;
    logic       p2_req = 1'b0;
    logic [9:0] p1_x = '0;
    logic [9:0] p1_y = '0;
    logic [9:0] p2_x = '0;
    logic [9:0] p2_y = '0;
    logic       bomb_active;
    logic [9:0] bomb_x;
    logic [9:0] bomb_y;
    logic [5:0] bomb_rad;
    logic       bomb_owner;
    logic       p1_grant;
    logic       p2_grant;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [1:0] state;

    always #5 clk = ~clk;

    bomb_game_controller #(
        .FUSE_TICKS (FUSE),
        .RAD_INIT   (RI),
        .RAD_STEP   (RS),
        .RAD_MAX    (RM),
        .WIN_SCORE  (WIN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .start       (start),
        .p1_req      (p1_req),
        .p2_req      (p2_req),
        .p1_x        (p1_x),
        .p1_y        (p1_y),
        .p2_x        (p2_x),
        .p2_y        (p2_y),
        .bomb_active (bomb_active),
        .bomb_x      (bomb_x),
        .bomb_y      (bomb_y),
        .bomb_rad    (bomb_rad),
        .bomb_owner  (bomb_owner),
        .p1_grant    (p1_grant),
        .p2_grant    (p2_grant),
        .p1_score    (p1_score),
        .p2_score    (p2_score),
        .state       (state)
    );

    typedef struct packed {
        logic [1:0] st;
        logic       act;
        logic [9:0] bx;
        logic [9:0] by;
        logic [5:0] rad;
        logic       own;
        logic       g1;
        logic       g2;
        logic [3:0] s1;
        logic [3:0] s2;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail = 0;

    // Game model: phase 0 idle, 1 slot/fuse, 2 blast, 3 over.
    int m_st, m_act, m_bx, m_by, m_rad, m_own;
    int m_g1, m_g2, m_s1, m_s2, m_fuse, m_h1, m_h2, m_last;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int sat(input int v);
        return (v > WIN) ? WIN : v;
    endfunction

    task automatic model_reset();
        m_st = 0; m_act = 0; m_bx = 0; m_by = 0; m_rad = 0; m_own = 0;
        m_g1 = 0; m_g2 = 0; m_s1 = 0; m_s2 = 0; m_fuse = 0;
        m_h1 = 0; m_h2 = 0; m_last = 1;
    endtask

    task automatic score_hit(input int victim);
        if (victim != m_own) begin
            if (m_own == 0) m_s1 = sat(m_s1 + 1);
            else m_s2 = sat(m_s2 + 1);
        end else begin
            if (m_own == 0) m_s2 = sat(m_s2 + 1);
            else m_s1 = sat(m_s1 + 1);
        end
    endtask

    task automatic model(input bit tk, input bit st, input bit r1,
                         input bit r2, input int x1, input int y1,
                         input int x2, input int y2);
        int who;
        bit hit1;
        bit hit2;
        m_g1 = 0;
        m_g2 = 0;
        if (!tk) return;
        case (m_st)
            0: if (st) begin
                m_s1 = 0; m_s2 = 0; m_h1 = 0; m_h2 = 0; m_act = 0; m_st = 1;
            end
            1: begin
                if (!st) begin
                    m_st = 0; m_act = 0; m_rad = 0; m_fuse = 0;
                end else if (m_act == 0) begin
                    who = -1;
                    if (r1 && r2) who = 1 - m_last;
                    else if (r1) who = 0;
                    else if (r2) who = 1;
                    if (who >= 0) begin
                        m_last = who; m_own = who; m_act = 1; m_fuse = FUSE;
                        m_bx = (who == 1) ? x2 : x1;
                        m_by = (who == 1) ? y2 : y1;
                        if (who == 1) m_g2 = 1;
                        else m_g1 = 1;
                    end
                end else begin
                    m_fuse--;
                    if (m_fuse == 0) begin
                        m_st = 2; m_rad = RI; m_h1 = 0; m_h2 = 0;
                    end
                end
            end
            2: begin
                hit1 = iabs(x1 - m_bx) <= m_rad && iabs(y1 - m_by) <= m_rad;
                hit2 = iabs(x2 - m_bx) <= m_rad && iabs(y2 - m_by) <= m_rad;
                if (hit1 && m_h1 == 0) begin m_h1 = 1; score_hit(0); end
                if (hit2 && m_h2 == 0) begin m_h2 = 1; score_hit(1); end
                if (m_s1 == WIN || m_s2 == WIN) begin
                    m_st = 3; m_act = 0; m_rad = 0;
                end else if (!st) begin
                    m_st = 0; m_act = 0; m_rad = 0;
                end else if (m_rad == RM) begin
                    m_st = 1; m_act = 0; m_rad = 0;
                end else begin
                    m_rad = (m_rad + RS > RM) ? RM : m_rad + RS;
                end
            end
            default: if (!st) m_st = 0;
        endcase
    endtask

    function automatic exp_t mexp();
        exp_t e;
        e.st = 2'(m_st); e.act = 1'(m_act);
        e.bx = 10'(m_bx); e.by = 10'(m_by); e.rad = 6'(m_rad);
        e.own = 1'(m_own); e.g1 = 1'(m_g1); e.g2 = 1'(m_g2);
        e.s1 = 4'(m_s1); e.s2 = 4'(m_s2);
        return e;
    endfunction

    function automatic exp_t dut_vec();
        return {state, bomb_active, bomb_x, bomb_y, bomb_rad, bomb_owner,
                p1_grant, p2_grant, p1_score, p2_score};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every registered output update is compared to the model.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                mon_e = q.pop_front();
                n_tests++;
                if (dut_vec() !== mon_e) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t: got %h, expected %h",
                             $time, dut_vec(), mon_e);
                end
            end
        end
    end

    task automatic step(input bit tk, input bit st, input bit r1,
                        input bit r2, input int x1, input int y1,
                        input int x2, input int y2);
        tick = tk; start = st; p1_req = r1; p2_req = r2;
        p1_x = 10'(x1); p1_y = 10'(y1); p2_x = 10'(x2); p2_y = 10'(y2);
        model(tk, st, r1, r2, x1, y1, x2, y2);
        q.push_back(mexp());
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic hold(input int n, input int x1, input int y1,
                        input int x2, input int y2);
        for (int i = 0; i < n; i++) step(1, 1, 0, 0, x1, y1, x2, y2);
    endtask

    task automatic do_reset(input string name);
        reset = 1'b0;
        model_reset();
        #1;
        chk({name, "_outputs"}, 32'(dut_vec()), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    function automatic int rpos();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 0;
        if (r == 1) return 1023;
        return 480 + int'($urandom_range(0, 60));
    endfunction

    int exp_g2[3] = '{0, 1, 0};

    initial begin
        model_reset();
        #1;
        chk("reset_outputs", 32'(dut_vec()), 32'd0);
        @(negedge clk);
        #1;
        reset = 1'b1;

        // First bomb: grant, pulse width, ignored request, fuse, blast
        step(1, 1, 0, 0, 100, 240, 120, 240);
        chk("start_state", state, 1);
        step(1, 1, 1, 0, 100, 240, 120, 240);
        chk("grant_p1", p1_grant, 1);
        chk("grant_xy", {bomb_x, bomb_y}, {10'd100, 10'd240});
        chk("grant_owner", bomb_owner, 0);
        chk("grant_active", bomb_active, 1);
        step(0, 1, 0, 0, 300, 300, 120, 240);
        chk("grant_pulse_end", p1_grant, 0);
        step(1, 1, 0, 1, 300, 300, 120, 240);
        chk("busy_req_ignored", p2_grant, 0);
        hold(30, 300, 300, 120, 240);
        chk("fuse_31_state", state, 1);
        hold(1, 300, 300, 120, 240);
        chk("blast_state", state, 2);
        chk("blast_rad_init", bomb_rad, RI);
        hold(3, 300, 300, 120, 240);
        chk("no_hit_before_20", p1_score, 0);
        hold(1, 300, 300, 120, 240);
        chk("hit_at_20", p1_score, 1);
        hold(4, 300, 300, 120, 240);
        chk("blast_over_active", bomb_active, 0);
        chk("blast_over_state", state, 1);
        chk("scored_once", {p1_score, p2_score}, {4'd1, 4'd0});

        // Both players on the bomb tile score together
        step(1, 1, 1, 0, 500, 500, 500, 500);
        hold(32, 500, 500, 500, 500);
        hold(1, 500, 500, 500, 500);
        chk("dual_hit", {p1_score, p2_score}, {4'd2, 4'd1});
        hold(2, 500, 500, 500, 500);
        chk("pre_reset_rad", bomb_rad, 20);
        do_reset("midblast_reset");

        // Round robin with both requesting each time
        step(1, 1, 0, 0, 10, 10, 20, 20);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 1, 1, 10, 10, 20, 20);
            chk("rr_p2_grant", p2_grant, exp_g2[i]);
            chk("rr_p1_grant", p1_grant, 1 - exp_g2[i]);
            step(1, 0, 0, 0, 10, 10, 20, 20);
            step(1, 1, 0, 0, 10, 10, 20, 20);
        end

        // Score to the win, then leave and restart
        do_reset("pre_win_reset");
        step(1, 1, 0, 0, 10, 10, 10, 10);
        for (int k = 1; k <= 10; k++) begin
            step(1, 1, 1, 0, 10, 10, 10, 10);
            hold(33, 900, 900, 10, 10);
            if (k < 10) hold(7, 900, 900, 10, 10);
            if (k == 9) chk("score_nine", p1_score, 9);
        end
        chk("win_score", p1_score, WIN);
        chk("win_state", state, 3);
        chk("win_clears", {bomb_active, bomb_rad}, 0);
        step(1, 1, 1, 1, 10, 10, 10, 10);
        chk("done_holds", state, 3);
        step(1, 0, 0, 0, 10, 10, 10, 10);
        chk("done_to_idle", state, 0);
        chk("idle_keeps_score", p1_score, WIN);
        step(1, 1, 0, 0, 10, 10, 10, 10);
        chk("restart_scores", {p1_score, p2_score}, 0);

        // Randomised play against the model
        do_reset("pre_random_reset");
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) != 0,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 rpos(), rpos(), rpos(), rpos());
        end

        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
